flag_sequencer: RTL and testbench
=================================

// Module: flag_sequencer
// PURPOSE
// - Owns the 3-bit condition flag register (bit0 Z, bit1 C, bit2 N) beside the Execute stage ALU.
// - Arbitrates flag writes from ALU results, taken-branch flag clears, interrupt entry and RTI.
// - Saves flags to a LIFO on interrupt entry and restores them on RTI through a small FSM.
// - busy stalls the pipeline while a save or restore is in progress.
// PARAMETERS
// - STACK_DEPTH  4  saved-flag entries, >=1; used only when FLAG_SEQ_NESTED_INT_EN is defined.
// - FLAG_W       3  flag register width; bit positions are fixed as above.
// PORTS
// - clk             in   1       clock; all state updates on rising edge
// - reset           in   1       asynchronous, active-low reset
// - stall           in   1       pipeline stall; freezes flags and request acceptance
// - alu_flag_valid  in   1       alu_flag carries a valid ALU result this cycle
// - alu_flag        in   FLAG_W  flags produced by the ALU
// - branch_taken    in   1       conditional branch resolved taken this cycle
// - branch_sel      in   2       00 Z, 01 C, 10 N, 11 unconditional
// - int_req         in   1       interrupt entry request; level, held until int_ack
// - rti             in   1       return-from-interrupt; single-cycle pulse
// - flag_reg        out  FLAG_W  architectural flags
// - int_ack         out  1       one-cycle pulse while in SAVE
// - busy            out  1       1 in SAVE or RESTORE
// - stack_empty     out  1       no saved entries
// - stack_full      out  1       saved-entry count == depth
// - stack_err       out  1       sticky; overflow or underflow occurred
// BEHAVIOUR
// - Reset (asynchronous): flag_reg=000, state=IDLE, count=0, int_ack=0, busy=0, stack_err=0, stack_empty=1, stack_full=0.
// - States: IDLE, SAVE, RESTORE. busy=(state!=IDLE). int_ack=(state==SAVE).
// - Request acceptance in IDLE with stall=0. Priority: rti > int_req > branch_taken > alu_flag_valid.
// - Simultaneous requests: only the highest-priority request acts in that cycle. Lower-priority requests are dropped, except int_req, which the requester keeps holding.
// - rti accepted: state<=RESTORE on the rising edge. Next edge pops the top entry into flag_reg, state<=IDLE.
// - rti with stack empty: still enters RESTORE. The pop edge loads flag_reg=000 and sets stack_err; count stays 0.
// - int_req accepted while stack not full: state<=SAVE. Next edge pushes flag_reg, sets flag_reg=000, state<=IDLE.
// - Latency: flags read back 2 edges after request sampling, for both save and restore.
// - int_req while stack full: not acknowledged, state stays IDLE, stack_err set. The ALU and branch paths proceed that cycle.
// - branch_taken (IDLE, no rti or int_req): clears flag_reg[branch_sel] (00 Z, 01 C, 10 N). branch_sel=11 leaves flags unchanged.
// - alu_flag_valid (IDLE, none above): flag_reg<=alu_flag; X/Z bits in alu_flag resolve to 0.
// - stall=1: flag_reg holds and nothing is accepted. SAVE and RESTORE already entered still complete on the next edge.
// - Inputs other than stall are ignored during SAVE and RESTORE.
// - Stack pointer: count 0..depth with no wrap. stack_full=(count==depth), stack_empty=(count==0).
// - Reset mid-SAVE or mid-RESTORE: abort immediately and clear the stack; no partial push or pop is observable.
// - stack_err clears only on reset.
// CONFIGURATION
// - FLAG_SEQ_NESTED_INT_EN defined: stack holds STACK_DEPTH entries, so nested interrupts are allowed.
// - FLAG_SEQ_NESTED_INT_EN undefined: a single save register, effective depth 1, and STACK_DEPTH is ignored.
//   - A second int_req before rti takes the full path: stack_err set, no int_ack.
// TESTING
// - ALU update: reset, alu_flag_valid=1, alu_flag=101 -> flag_reg=101 after 1 edge, busy=0.
// - Branch clear: flag_reg=111, branch_taken=1, branch_sel=01 -> flag_reg=101. With branch_sel=11 -> flag_reg stays 111.
// - Save/restore: flag_reg=011, int_req=1 -> int_ack high 1 cycle, flag_reg=000 and stack_empty=0 after 2 edges.
//   - Then alu_flag=110, then rti -> flag_reg=011 after 2 edges, stack_empty=1.
// - Priority: rti and int_req in the same IDLE cycle with 1 entry saved -> RESTORE taken, int_ack=0.
//   - int_req still held -> SAVE follows on the next acceptance.
// - Overflow (nested enabled, depth 4): 5 interrupts without rti -> 4 int_acks, stack_full=1.
//   - 5th request gives no int_ack; stack_err=1.
// - Underflow and reset: rti with stack empty -> flag_reg=000, stack_err=1.
//   - reset low mid-SAVE -> all outputs at reset values immediately.

Source files
------------

// File: rtl/flag_sequencer_if.sv
// Request/status bundle between the Execute stage and flag_sequencer.
// master: pipeline side driving requests; slave: the flag sequencer.
interface flag_sequencer_if #(
  parameter int FLAG_W = 3
);
  logic              stall;
  logic              alu_flag_valid;
  logic [FLAG_W-1:0] alu_flag;
  logic              branch_taken;
  logic [1:0]        branch_sel;
  logic              int_req;
  logic              rti;
  logic [FLAG_W-1:0] flag_reg;
  logic              int_ack;
  logic              busy;
  logic              stack_empty;
  logic              stack_full;
  logic              stack_err;

  modport master (
    output stall, alu_flag_valid, alu_flag, branch_taken, branch_sel, int_req, rti,
    input  flag_reg, int_ack, busy, stack_empty, stack_full, stack_err
  );

  modport slave (
    input  stall, alu_flag_valid, alu_flag, branch_taken, branch_sel, int_req, rti,
    output flag_reg, int_ack, busy, stack_empty, stack_full, stack_err
  );
endinterface

// File: rtl/flag_sequencer.sv
// flag_sequencer: condition flag register (bit0 Z, bit1 C, bit2 N) with
// interrupt save/restore through a LIFO of saved flags.
// Optional feature macro: FLAG_SEQ_NESTED_INT_EN
//   defined   -> STACK_DEPTH saved entries (nested interrupts)
//   undefined -> single save register, depth 1, STACK_DEPTH ignored
//
// state   | meaning
// IDLE    | accepting requests when not stalled
// SAVE    | pushing flag_reg, int_ack high; clears flags on exit
// RESTORE | popping top entry into flag_reg (underflow loads 0, sets stack_err)
module flag_sequencer #(
  parameter int STACK_DEPTH = 4,
  parameter int FLAG_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  flag_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2
  } state_t;

`ifdef FLAG_SEQ_NESTED_INT_EN
  localparam int DEPTH = STACK_DEPTH;
`else
  localparam int DEPTH = 1;
`endif
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [FLAG_W-1:0] r_flag;
  logic [FLAG_W-1:0] w_flag_nxt;
  logic [CNT_W-1:0]  r_count;
  logic              r_err;
  logic              w_err_set;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [FLAG_W-1:0] w_alu_clean;
  logic [FLAG_W-1:0] w_top;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);

  // Unknown ALU flag bits resolve to 0 (an X condition takes the else path).
  always_comb begin
    w_alu_clean = '0;
    for (int i = 0; i < FLAG_W; i++) begin
      if (bus.alu_flag[i] == 1'b1) w_alu_clean[i] = 1'b1;
      else                         w_alu_clean[i] = 1'b0;
    end
  end

`ifdef FLAG_SEQ_NESTED_INT_EN
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [FLAG_W-1:0] r_stack [DEPTH];
  logic [CNT_W-1:0]  w_cnt_dec;
  logic [IDX_W-1:0]  w_push_idx;
  logic [IDX_W-1:0]  w_top_idx;

  assign w_cnt_dec  = r_count - CNT_W'(1);
  assign w_push_idx = r_count[IDX_W-1:0];
  assign w_top_idx  = w_cnt_dec[IDX_W-1:0];
  assign w_top      = r_stack[w_top_idx];

  // LIFO storage; cleared on reset so an aborted save leaves nothing behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
    end else if (w_push) begin
      r_stack[w_push_idx] <= r_flag;
    end
  end
`else
  logic [FLAG_W-1:0] r_save;

  assign w_top = r_save;

  // Single save slot used when nesting is disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_save <= '0;
    else if (w_push) r_save <= r_flag;
  end
`endif

  // Next-state, flag update and request arbitration (rti > int_req > branch > alu).
  always_comb begin
    w_state_nxt = r_state;
    w_flag_nxt  = r_flag;
    w_err_set   = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!bus.stall) begin
          if (bus.rti) begin
            w_state_nxt = ST_RESTORE;
          end else if (bus.int_req && !w_full) begin
            w_state_nxt = ST_SAVE;
          end else begin
            // A refused interrupt flags the overflow but does not block the ALU/branch paths.
            if (bus.int_req) w_err_set = 1'b1;
            if (bus.branch_taken) begin
              if (bus.branch_sel != 2'b11) w_flag_nxt[bus.branch_sel] = 1'b0;
            end else if (bus.alu_flag_valid) begin
              w_flag_nxt = w_alu_clean;
            end
          end
        end
      end
      ST_SAVE: begin
        w_push      = 1'b1;
        w_flag_nxt  = '0;
        w_state_nxt = ST_IDLE;
      end
      ST_RESTORE: begin
        w_state_nxt = ST_IDLE;
        if (w_empty) begin
          w_flag_nxt = '0;
          w_err_set  = 1'b1;
        end else begin
          w_flag_nxt = w_top;
          w_pop      = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, flags, stack pointer and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_flag  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_flag  <= w_flag_nxt;
      if (w_push)      r_count <= r_count + CNT_W'(1);
      else if (w_pop)  r_count <= r_count - CNT_W'(1);
      if (w_err_set)   r_err <= 1'b1;
    end
  end

  assign bus.flag_reg    = r_flag;
  assign bus.int_ack     = (r_state == ST_SAVE);
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.stack_empty = w_empty;
  assign bus.stack_full  = w_full;
  assign bus.stack_err   = r_err;

endmodule

// File: tb/tb_flag_sequencer.sv
// Directed bench for flag_sequencer; builds with or without FLAG_SEQ_NESTED_INT_EN.
module tb_flag_sequencer;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  flag_sequencer_if #(.FLAG_W(3)) bus ();

  flag_sequencer #(.STACK_DEPTH(4), .FLAG_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall          = 1'b0;
    bus.alu_flag_valid = 1'b0;
    bus.alu_flag       = 3'b000;
    bus.branch_taken   = 1'b0;
    bus.branch_sel     = 2'b00;
    bus.int_req        = 1'b0;
    bus.rti            = 1'b0;
  endtask

  task automatic load(input logic [2:0] v);
    bus.alu_flag_valid = 1'b1;
    bus.alu_flag       = v;
    step();
    bus.alu_flag_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    checks++; if (bus.flag_reg !== 3'b000) begin errors++; $display("FAIL reset_flag got %b want 000", bus.flag_reg); end
    checks++; if ({bus.int_ack, bus.busy, bus.stack_err, bus.stack_empty, bus.stack_full} !== 5'b00010) begin
      errors++; $display("FAIL reset_status got %b want 00010", {bus.int_ack, bus.busy, bus.stack_err, bus.stack_empty, bus.stack_full});
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_alu();
    load(3'b101);
    checks++; if (bus.flag_reg !== 3'b101) begin errors++; $display("FAIL alu_update got %b want 101", bus.flag_reg); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL alu_busy got %b want 0", bus.busy); end
    load(3'b010);
    checks++; if (bus.flag_reg !== 3'b010) begin errors++; $display("FAIL alu_update2 got %b want 010", bus.flag_reg); end
  endtask

  task automatic test_branch();
    logic [1:0] sels [4] = '{2'b01, 2'b11, 2'b00, 2'b10};
    logic [2:0] exps [4] = '{3'b101, 3'b111, 3'b110, 3'b011};
    for (int i = 0; i < 4; i++) begin
      load(3'b111);
      bus.branch_taken = 1'b1;
      bus.branch_sel   = sels[i];
      step();
      bus.branch_taken = 1'b0;
      checks++; if (bus.flag_reg !== exps[i]) begin errors++; $display("FAIL branch_sel%0d got %b want %b", i, bus.flag_reg, exps[i]); end
    end
    load(3'b111);
    bus.branch_taken   = 1'b1;
    bus.branch_sel     = 2'b00;
    bus.alu_flag_valid = 1'b1;
    bus.alu_flag       = 3'b010;
    step();
    idle_inputs();
    checks++; if (bus.flag_reg !== 3'b110) begin errors++; $display("FAIL branch_over_alu got %b want 110", bus.flag_reg); end
  endtask

  task automatic test_save_restore();
    load(3'b011);
    bus.int_req = 1'b1;
    step();
    checks++; if (bus.int_ack !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL save_ack ack=%b busy=%b want 1 1", bus.int_ack, bus.busy); end
    checks++; if (bus.flag_reg !== 3'b011) begin errors++; $display("FAIL save_mid_flag got %b want 011", bus.flag_reg); end
    bus.int_req = 1'b0;
    step();
    checks++; if (bus.int_ack !== 1'b0) begin errors++; $display("FAIL save_ack_pulse got %b want 0", bus.int_ack); end
    checks++; if (bus.flag_reg !== 3'b000 || bus.stack_empty !== 1'b0) begin errors++; $display("FAIL save_done flag=%b empty=%b want 000 0", bus.flag_reg, bus.stack_empty); end
    load(3'b110);
    checks++; if (bus.flag_reg !== 3'b110) begin errors++; $display("FAIL isr_alu got %b want 110", bus.flag_reg); end
    bus.rti = 1'b1;
    step();
    bus.rti = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.flag_reg !== 3'b110) begin errors++; $display("FAIL restore_mid busy=%b flag=%b want 1 110", bus.busy, bus.flag_reg); end
    step();
    checks++; if (bus.flag_reg !== 3'b011 || bus.stack_empty !== 1'b1) begin errors++; $display("FAIL restore_done flag=%b empty=%b want 011 1", bus.flag_reg, bus.stack_empty); end
    checks++; if (bus.busy !== 1'b0 || bus.stack_err !== 1'b0) begin errors++; $display("FAIL restore_status busy=%b err=%b want 0 0", bus.busy, bus.stack_err); end
  endtask

  task automatic test_stall();
    load(3'b101);
    bus.stall          = 1'b1;
    bus.alu_flag_valid = 1'b1;
    bus.alu_flag       = 3'b010;
    bus.int_req        = 1'b1;
    step();
    checks++; if (bus.flag_reg !== 3'b101 || bus.int_ack !== 1'b0) begin errors++; $display("FAIL stall_hold flag=%b ack=%b want 101 0", bus.flag_reg, bus.int_ack); end
    bus.stall          = 1'b0;
    bus.alu_flag_valid = 1'b0;
    step();
    checks++; if (bus.int_ack !== 1'b1) begin errors++; $display("FAIL stall_release_ack got %b want 1", bus.int_ack); end
    bus.int_req = 1'b0;
    bus.stall   = 1'b1;
    step();
    checks++; if (bus.busy !== 1'b0 || bus.flag_reg !== 3'b000) begin errors++; $display("FAIL stall_save_completes busy=%b flag=%b want 0 000", bus.busy, bus.flag_reg); end
    bus.stall = 1'b0;
    bus.rti   = 1'b1;
    step();
    bus.rti = 1'b0;
    step();
    checks++; if (bus.flag_reg !== 3'b101) begin errors++; $display("FAIL stall_restore got %b want 101", bus.flag_reg); end
  endtask

  task automatic test_priority();
    load(3'b011);
    bus.int_req = 1'b1;
    step();
    bus.int_req = 1'b0;
    step();
    load(3'b100);
    bus.rti     = 1'b1;
    bus.int_req = 1'b1;
    step();
    bus.rti = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.int_ack !== 1'b0) begin errors++; $display("FAIL prio_rti busy=%b ack=%b want 1 0", bus.busy, bus.int_ack); end
    step();
    checks++; if (bus.flag_reg !== 3'b011 || bus.stack_empty !== 1'b1) begin errors++; $display("FAIL prio_pop flag=%b empty=%b want 011 1", bus.flag_reg, bus.stack_empty); end
    step();
    checks++; if (bus.int_ack !== 1'b1) begin errors++; $display("FAIL prio_save_follows got %b want 1", bus.int_ack); end
    bus.int_req = 1'b0;
    step();
    checks++; if (bus.flag_reg !== 3'b000 || bus.stack_empty !== 1'b0) begin errors++; $display("FAIL prio_saved flag=%b empty=%b want 000 0", bus.flag_reg, bus.stack_empty); end
    bus.rti = 1'b1;
    step();
    bus.rti = 1'b0;
    step();
    checks++; if (bus.flag_reg !== 3'b011) begin errors++; $display("FAIL prio_restore got %b want 011", bus.flag_reg); end
  endtask

  task automatic test_overflow();
    int acks;
    int n;
`ifdef FLAG_SEQ_NESTED_INT_EN
    n = 4;
`else
    n = 1;
`endif
    do_reset();
    acks = 0;
    for (int i = 0; i < n; i++) begin
      bus.int_req = 1'b1;
      step();
      if (bus.int_ack === 1'b1) acks++;
      bus.int_req = 1'b0;
      step();
    end
    checks++; if (acks != n) begin errors++; $display("FAIL ovf_acks got %0d want %0d", acks, n); end
    checks++; if (bus.stack_full !== 1'b1 || bus.stack_err !== 1'b0) begin errors++; $display("FAIL ovf_full full=%b err=%b want 1 0", bus.stack_full, bus.stack_err); end
    bus.int_req        = 1'b1;
    bus.alu_flag_valid = 1'b1;
    bus.alu_flag       = 3'b101;
    step();
    idle_inputs();
    checks++; if (bus.int_ack !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL ovf_noack ack=%b busy=%b want 0 0", bus.int_ack, bus.busy); end
    checks++; if (bus.stack_err !== 1'b1 || bus.flag_reg !== 3'b101) begin errors++; $display("FAIL ovf_err err=%b flag=%b want 1 101", bus.stack_err, bus.flag_reg); end
    bus.rti = 1'b1;
    step();
    bus.rti = 1'b0;
    step();
    checks++; if (bus.stack_err !== 1'b1 || bus.stack_full !== 1'b0) begin errors++; $display("FAIL ovf_sticky err=%b full=%b want 1 0", bus.stack_err, bus.stack_full); end
  endtask

  task automatic test_underflow();
    do_reset();
    load(3'b101);
    bus.rti = 1'b1;
    step();
    bus.rti = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL unf_restore busy got %b want 1", bus.busy); end
    step();
    checks++; if (bus.flag_reg !== 3'b000 || bus.stack_err !== 1'b1) begin errors++; $display("FAIL unf_result flag=%b err=%b want 000 1", bus.flag_reg, bus.stack_err); end
    checks++; if (bus.stack_empty !== 1'b1) begin errors++; $display("FAIL unf_empty got %b want 1", bus.stack_empty); end
  endtask

  task automatic test_reset_mid_save();
    do_reset();
    load(3'b011);
    bus.int_req = 1'b1;
    step();
    bus.int_req = 1'b0;
    checks++; if (bus.int_ack !== 1'b1) begin errors++; $display("FAIL rst_mid_enter ack got %b want 1", bus.int_ack); end
    #1;
    reset = 1'b0;
    #1;
    checks++; if ({bus.flag_reg, bus.int_ack, bus.busy, bus.stack_err, bus.stack_empty, bus.stack_full} !== 8'b000_00010) begin
      errors++; $display("FAIL rst_mid_async got %b want 00000010", {bus.flag_reg, bus.int_ack, bus.busy, bus.stack_err, bus.stack_empty, bus.stack_full});
    end
    step();
    reset = 1'b1;
    step();
    checks++; if (bus.stack_empty !== 1'b1 || bus.flag_reg !== 3'b000) begin errors++; $display("FAIL rst_mid_nopush empty=%b flag=%b want 1 000", bus.stack_empty, bus.flag_reg); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    idle_inputs();
    test_reset();
    test_alu();
    test_branch();
    test_save_restore();
    test_stall();
    test_priority();
    test_overflow();
    test_underflow();
    test_reset_mid_save();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
